// File: rtl/dram_axi_pkg.sv
// -----------------------------------------------------------------------------
// dram_axi_pkg
// Shared definitions for the DRAM command to AXI4 master bridge.
//   - rd_state_t / wr_state_t : read and write channel FSM encodings
//   - AXI_BURST_INCR, RESP_OKAY : fixed AXI field values
//   - axi_size()              : AxSIZE encoding for a given data bus width
// -----------------------------------------------------------------------------
package dram_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // Every beat uses the full bus, so AxSIZE is log2 of the bus width in bytes.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/dram_axi_master_read_ch.sv
// -----------------------------------------------------------------------------
// dram_axi_read_ch
// Read half of the bridge: latches one read command, issues a single AXI4 INCR
// burst on AR, and forwards each R beat through a register stage to the
// consumer, honouring its buffer-full backpressure.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_addr/i_len/i_en           read command (len = beats-1, en is a pulse)
//   o_data/o_data_valid         registered read beat, one pulse per beat
//   o_busy                      command in flight
//   i_buffer_full               consumer backpressure
//   o_err                       one-cycle pulse on bad RRESP or RLAST mismatch
//   o_ar*/i_arready             AXI4 read address channel (addr, len, valid)
//   i_r*/o_rready               AXI4 read data channel
// -----------------------------------------------------------------------------
module dram_axi_read_ch
    import dram_axi_pkg::*;
#(
    parameter int ADDR_W = 39,
    parameter int DATA_W = 128
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic              i_en,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_busy,
    input  logic              i_buffer_full,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [7:0]        o_arlen,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast,
    input  logic              i_rvalid,
    output logic              o_rready
);

    rd_state_t         r_state;
    rd_state_t         w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_err;
    logic              w_r_hs;
    logic              w_last_beat;

    assign w_r_hs      = (r_state == R_DATA) && i_rvalid && o_rready;
    assign w_last_beat = (r_cnt == r_len);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The burst ends on our own beat count, not on RLAST, so a misbehaving
    // slave cannot stall or prematurely end the command.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            R_IDLE:  if (i_en)                   w_state_next = R_ADDR;
            R_ADDR:  if (i_arready)              w_state_next = R_DATA;
            R_DATA:  if (w_r_hs && w_last_beat)  w_state_next = R_IDLE;
            default:                             w_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_r_hs;
            r_err   <= 1'b0;
            if (r_state == R_IDLE && i_en) begin
                r_addr <= i_addr;
                r_len  <= i_len;
                r_cnt  <= '0;
            end
            if (w_r_hs) begin
                r_data <= i_rdata;
                r_cnt  <= r_cnt + 8'd1;
                r_err  <= (i_rresp != RESP_OKAY) || (i_rlast != w_last_beat);
            end
        end
    end

    assign o_araddr     = r_addr;
    assign o_arlen      = r_len;
    assign o_arvalid    = (r_state == R_ADDR);
    assign o_rready     = (r_state == R_DATA) && !i_buffer_full;
    assign o_busy       = (r_state != R_IDLE);
    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_err        = r_err;

endmodule

// File: rtl/dram_axi_master.sv
// -----------------------------------------------------------------------------
// dram_axi_master
// Bridges the image pipeline's simple DRAM read/write command ports to an AXI4
// master. Each command is a single INCR burst of len+1 full-width beats. Read
// and write channels are independent and may overlap.
// Ports:
//   s_axi_aclk, s_axi_aresetn        clock, asynchronous active-low reset
//   dram_read_*  / dram_buffer_full  read command, registered read beats, busy
//   dram_write_* (cmd, data source)  write command, beat handshake, busy
//   dram_error                       sticky error (bad RESP or RLAST mismatch)
//   m_axi_ar* / m_axi_r*             AXI4 read address / data channels
//   m_axi_aw* / m_axi_w* / m_axi_b*  AXI4 write address / data / response
// -----------------------------------------------------------------------------
module dram_axi_master
    import dram_axi_pkg::*;
#(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_aresetn,
    input  logic [DRAM_ADDR_WIDTH-1:0]   dram_read_addr,
    input  logic [7:0]                   dram_read_len,
    input  logic                         dram_read_en,
    output logic [DRAM_DATA_WIDTH-1:0]   dram_read_data,
    output logic                         dram_read_data_valid,
    output logic                         dram_read_busy,
    input  logic                         dram_buffer_full,
    input  logic [DRAM_ADDR_WIDTH-1:0]   dram_write_addr,
    input  logic [7:0]                   dram_write_len,
    input  logic                         dram_write_en,
    input  logic [DRAM_DATA_WIDTH-1:0]   dram_write_data,
    input  logic                         dram_write_valid,
    output logic                         dram_write_ready,
    output logic                         dram_write_busy,
    output logic                         dram_error,
    output logic [DRAM_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    output logic [2:0]                   m_axi_arsize,
    output logic [1:0]                   m_axi_arburst,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    input  logic [DRAM_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rlast,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    output logic [DRAM_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                   m_axi_awlen,
    output logic [2:0]                   m_axi_awsize,
    output logic [1:0]                   m_axi_awburst,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [DRAM_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DRAM_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                         m_axi_wlast,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready
);

    localparam logic [2:0] BEAT_SIZE = axi_size(DRAM_DATA_WIDTH);

    logic w_rd_err;

    dram_axi_read_ch #(
        .ADDR_W (DRAM_ADDR_WIDTH),
        .DATA_W (DRAM_DATA_WIDTH)
    ) u_read_ch (
        .i_clk         (s_axi_aclk),
        .i_rst_n       (s_axi_aresetn),
        .i_addr        (dram_read_addr),
        .i_len         (dram_read_len),
        .i_en          (dram_read_en),
        .o_data        (dram_read_data),
        .o_data_valid  (dram_read_data_valid),
        .o_busy        (dram_read_busy),
        .i_buffer_full (dram_buffer_full),
        .o_err         (w_rd_err),
        .o_araddr      (m_axi_araddr),
        .o_arlen       (m_axi_arlen),
        .o_arvalid     (m_axi_arvalid),
        .i_arready     (m_axi_arready),
        .i_rdata       (m_axi_rdata),
        .i_rresp       (m_axi_rresp),
        .i_rlast       (m_axi_rlast),
        .i_rvalid      (m_axi_rvalid),
        .o_rready      (m_axi_rready)
    );

    assign m_axi_arsize  = BEAT_SIZE;
    assign m_axi_arburst = AXI_BURST_INCR;

    // ---------------- write channel ----------------
    // W_ADDR: AW outstanding, W beats may already flow.
    // W_DATA: AW done, W beats still flowing.
    // r_wdone remembers that the last W beat finished while AW was still
    // pending, so W_ADDR can go straight to W_RESP on the AW handshake.
    wr_state_t                 r_wstate;
    wr_state_t                 w_wstate_next;
    logic [DRAM_ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]                r_wlen;
    logic [7:0]                r_wcnt;
    logic                      r_wdone;
    logic                      r_error;
    logic                      w_w_active;
    logic                      w_w_hs;
    logic                      w_w_last_hs;
    logic                      w_aw_hs;
    logic                      w_b_hs;
    logic                      w_wlast;

    assign w_w_active  = ((r_wstate == W_ADDR) || (r_wstate == W_DATA)) && !r_wdone;
    assign w_w_hs      = w_w_active && dram_write_valid && m_axi_wready;
    assign w_wlast     = (r_wcnt == r_wlen);
    assign w_w_last_hs = w_w_hs && w_wlast;
    assign w_aw_hs     = (r_wstate == W_ADDR) && m_axi_awready;
    assign w_b_hs      = (r_wstate == W_RESP) && m_axi_bvalid;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE: if (dram_write_en) w_wstate_next = W_ADDR;
            W_ADDR: if (w_aw_hs)       w_wstate_next = (r_wdone || w_w_last_hs) ? W_RESP : W_DATA;
            W_DATA: if (w_w_last_hs)   w_wstate_next = W_RESP;
            W_RESP: if (m_axi_bvalid)  w_wstate_next = W_IDLE;
            default:                   w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_waddr <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
            r_wdone <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (r_wstate == W_IDLE && dram_write_en) begin
                r_waddr <= dram_write_addr;
                r_wlen  <= dram_write_len;
                r_wcnt  <= '0;
                r_wdone <= 1'b0;
            end
            if (w_w_hs) begin
                r_wcnt <= r_wcnt + 8'd1;
                if (w_wlast) begin
                    r_wdone <= 1'b1;
                end
            end
            if (w_rd_err || (w_b_hs && (m_axi_bresp != RESP_OKAY))) begin
                r_error <= 1'b1;
            end
        end
    end

    assign m_axi_awaddr     = r_waddr;
    assign m_axi_awlen      = r_wlen;
    assign m_axi_awsize     = BEAT_SIZE;
    assign m_axi_awburst    = AXI_BURST_INCR;
    assign m_axi_awvalid    = (r_wstate == W_ADDR);
    assign m_axi_wvalid     = w_w_active && dram_write_valid;
    assign m_axi_wdata      = w_w_active ? dram_write_data : '0;
    assign m_axi_wstrb      = '1;
    assign m_axi_wlast      = w_w_active && w_wlast;
    assign dram_write_ready = w_w_active && m_axi_wready;
    assign m_axi_bready     = (r_wstate == W_RESP);
    assign dram_write_busy  = (r_wstate != W_IDLE);
    assign dram_error       = r_error;

endmodule

// File: tb/tb_dram_axi_master.sv
`timescale 1ns/1ps
module tb_dram_axi_master;
    localparam int AW = 39;
    localparam int DW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic [AW-1:0]   dram_read_addr = '0;
    logic [7:0]      dram_read_len = '0;
    logic            dram_read_en = 1'b0;
    logic [DW-1:0]   dram_read_data;
    logic            dram_read_data_valid, dram_read_busy;
    logic            dram_buffer_full = 1'b0;
    logic [AW-1:0]   dram_write_addr = '0;
    logic [7:0]      dram_write_len = '0;
    logic            dram_write_en = 1'b0;
    logic [DW-1:0]   dram_write_data = '0;
    logic            dram_write_valid = 1'b0;
    logic            dram_write_ready, dram_write_busy, dram_error;
    logic [AW-1:0]   m_axi_araddr, m_axi_awaddr;
    logic [7:0]      m_axi_arlen, m_axi_awlen;
    logic [2:0]      m_axi_arsize, m_axi_awsize;
    logic [1:0]      m_axi_arburst, m_axi_awburst;
    logic            m_axi_arvalid, m_axi_awvalid;
    logic            m_axi_arready = 1'b1;
    logic            m_axi_awready = 1'b1;
    logic [DW-1:0]   m_axi_rdata = '0;
    logic [1:0]      m_axi_rresp = 2'b00;
    logic            m_axi_rlast = 1'b0;
    logic            m_axi_rvalid = 1'b0;
    logic            m_axi_rready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid;
    logic            m_axi_wready = 1'b1;
    logic [1:0]      m_axi_bresp = 2'b00;
    logic            m_axi_bvalid = 1'b0;
    logic            m_axi_bready;

    dram_axi_master #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .dram_read_addr(dram_read_addr), .dram_read_len(dram_read_len), .dram_read_en(dram_read_en),
        .dram_read_data(dram_read_data), .dram_read_data_valid(dram_read_data_valid),
        .dram_read_busy(dram_read_busy), .dram_buffer_full(dram_buffer_full),
        .dram_write_addr(dram_write_addr), .dram_write_len(dram_write_len), .dram_write_en(dram_write_en),
        .dram_write_data(dram_write_data), .dram_write_valid(dram_write_valid),
        .dram_write_ready(dram_write_ready), .dram_write_busy(dram_write_busy), .dram_error(dram_error),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    // ---------------- scoreboard ----------------
    logic [AW+7:0] exp_ar_q[$];
    logic [AW+7:0] exp_aw_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW:0]   exp_w_q[$];   // {wlast, wdata}
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_missing(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual beat with empty queue, required none at %0t", name, $time);
    endtask

    // ---------------- AXI slave + write-beat source ----------------
    int ar_lat = 0, aw_lat = 0, b_lat = 0, early_last = -1;
    logic [1:0] bresp_cfg = 2'b00;
    logic [AW-1:0] rb_addr_q[$];
    logic [7:0]    rb_len_q[$];
    logic [DW-1:0] wsrc_q[$];
    int r_idx = 0, ar_cnt = 0, aw_cnt = 0, b_cnt = 0;
    bit aw_done = 0, wl_done = 0;
    bit s_arv, s_ar_hs, s_r_hs, s_awv, s_aw_hs, s_w_hs, s_wlast, s_b_hs;
    logic [AW-1:0] s_araddr;
    logic [7:0]    s_arlen;

    always begin
        @(negedge clk);
        s_arv    = m_axi_arvalid;
        s_ar_hs  = m_axi_arvalid && m_axi_arready;
        s_araddr = m_axi_araddr;
        s_arlen  = m_axi_arlen;
        s_r_hs   = m_axi_rvalid && m_axi_rready;
        s_awv    = m_axi_awvalid;
        s_aw_hs  = m_axi_awvalid && m_axi_awready;
        s_w_hs   = m_axi_wvalid && m_axi_wready;
        s_wlast  = m_axi_wlast;
        s_b_hs   = m_axi_bvalid && m_axi_bready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            rb_addr_q.delete(); rb_len_q.delete(); wsrc_q.delete();
            r_idx = 0; ar_cnt = 0; aw_cnt = 0; b_cnt = 0;
            aw_done = 0; wl_done = 0; m_axi_bvalid = 1'b0;
        end else begin
            if (s_ar_hs) begin
                rb_addr_q.push_back(s_araddr); rb_len_q.push_back(s_arlen); ar_cnt = 0;
            end else if (s_arv) ar_cnt++;
            if (s_r_hs && rb_len_q.size() > 0) begin
                if (r_idx == int'(rb_len_q[0])) begin
                    void'(rb_addr_q.pop_front()); void'(rb_len_q.pop_front()); r_idx = 0;
                end else r_idx++;
            end
            if (s_aw_hs) begin aw_done = 1; aw_cnt = 0; end
            else if (s_awv) aw_cnt++;
            if (s_w_hs) begin
                if (wsrc_q.size() > 0) void'(wsrc_q.pop_front());
                if (s_wlast) wl_done = 1;
            end
            if (s_b_hs) begin
                m_axi_bvalid = 1'b0; aw_done = 0; wl_done = 0; b_cnt = 0;
            end else if (aw_done && wl_done && !m_axi_bvalid) begin
                if (b_cnt >= b_lat) begin m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; end
                else b_cnt++;
            end
        end
        m_axi_arready = (ar_cnt >= ar_lat);
        m_axi_awready = (aw_cnt >= aw_lat);
        if (rb_len_q.size() > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = DW'(rb_addr_q[0]) + DW'(r_idx * 16);   // memory returns each beat's address
            m_axi_rlast  = (early_last >= 0) ? (r_idx == early_last) : (r_idx == int'(rb_len_q[0]));
        end else begin
            m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
        end
        dram_write_valid = (wsrc_q.size() > 0);
        dram_write_data  = (wsrc_q.size() > 0) ? wsrc_q[0] : '0;
    end

    // ---------------- monitor ----------------
    int mon_rlen = 0, mon_rcnt = 0;
    bit mon_rd_end = 0, mon_b_end = 0, mon_aw = 0, mon_wl = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_rlen = 0; mon_rcnt = 0; mon_rd_end = 0; mon_b_end = 0; mon_aw = 0; mon_wl = 0;
        end else begin
            if (mon_rd_end) begin
                chk("rd_busy_fall", dram_read_busy, 0);
                chk("rd_last_valid", dram_read_data_valid, 1);
                mon_rd_end = 0;
            end
            if (mon_b_end) begin
                chk("wr_busy_fall", dram_write_busy, 0);
                mon_b_end = 0;
            end
            if (mon_aw && mon_wl) chk("bready_hold", m_axi_bready, 1);
            if (dram_read_data_valid) begin
                if (exp_rd_q.size() == 0) chk_missing("rd_data");
                else chk("rd_data", dram_read_data, exp_rd_q.pop_front());
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar_q.size() == 0) chk_missing("ar");
                else chk("ar_addr_len", {m_axi_araddr, m_axi_arlen}, exp_ar_q.pop_front());
                chk("ar_size_burst", {m_axi_arsize, m_axi_arburst}, {3'd4, 2'b01});
                mon_rlen = int'(m_axi_arlen); mon_rcnt = 0;
            end
            if (dram_read_busy && !m_axi_arvalid) chk("rready_vs_full", m_axi_rready, !dram_buffer_full);
            if (m_axi_rvalid && m_axi_rready) begin
                if (mon_rcnt == mon_rlen) begin mon_rd_end = 1; mon_rcnt = 0; end
                else mon_rcnt++;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw_q.size() == 0) chk_missing("aw");
                else chk("aw_addr_len", {m_axi_awaddr, m_axi_awlen}, exp_aw_q.pop_front());
                chk("aw_size_burst", {m_axi_awsize, m_axi_awburst}, {3'd4, 2'b01});
                mon_aw = 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_w_q.size() == 0) chk_missing("w");
                else chk("w_last_data", {m_axi_wlast, m_axi_wdata}, exp_w_q.pop_front());
                chk("w_strb", m_axi_wstrb, 16'hFFFF);
                if (m_axi_wlast) mon_wl = 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                mon_b_end = 1; mon_aw = 0; mon_wl = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_rd(input logic [AW-1:0] addr, input int len);
        exp_ar_q.push_back({addr, 8'(len)});
        for (int i = 0; i <= len; i++) exp_rd_q.push_back(DW'(addr) + DW'(i * 16));
        dram_read_addr = addr; dram_read_len = 8'(len); dram_read_en = 1'b1;
    endtask

    task automatic issue_wr(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] base);
        exp_aw_q.push_back({addr, 8'(len)});
        for (int i = 0; i <= len; i++) begin
            exp_w_q.push_back({(i == len), base + DW'(i)});
            wsrc_q.push_back(base + DW'(i));
        end
        dram_write_addr = addr; dram_write_len = 8'(len); dram_write_en = 1'b1;
    endtask

    task automatic pulse();
        tick();
        dram_read_en = 1'b0; dram_write_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int c = 0;
        while ((dram_read_busy || dram_write_busy) && c < max) begin tick(); c++; end
        chk(name, {dram_read_busy, dram_write_busy}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, m_axi_arvalid, 0);
        chk({tag, "_rready"}, m_axi_rready, 0);
        chk({tag, "_awvalid"}, m_axi_awvalid, 0);
        chk({tag, "_wvalid"}, m_axi_wvalid, 0);
        chk({tag, "_bready"}, m_axi_bready, 0);
        chk({tag, "_busys"}, {dram_read_busy, dram_write_busy}, 0);
        chk({tag, "_rd_valid"}, dram_read_data_valid, 0);
        chk({tag, "_wr_ready"}, dram_write_ready, 0);
        chk({tag, "_error"}, dram_error, 0);
        chk({tag, "_rd_data"}, dram_read_data, 0);
        chk({tag, "_addrs"}, {m_axi_araddr, m_axi_awaddr}, 0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // read len=3, immediate ARREADY, continuous RVALID
        issue_rd(39'h1000, 3);
        pulse();
        chk("t1_arvalid_busy", {m_axi_arvalid, dram_read_busy}, 2'b11);
        wait_idle("t1_idle", 100);
        tick();
        chk("t1_drained", exp_rd_q.size(), 0);

        // read len=7 with buffer_full toggling every 2 cycles
        issue_rd(39'h2000, 7);
        pulse();
        cyc = 0;
        while (dram_read_busy && cyc < 200) begin
            tick(); cyc++;
            if (cyc % 2 == 0) dram_buffer_full = ~dram_buffer_full;
        end
        dram_buffer_full = 1'b0;
        chk("t2_idle", dram_read_busy, 0);
        tick();
        chk("t2_drained", exp_rd_q.size(), 0);

        // write len=1, AWREADY delayed, W beats flow before AW
        aw_lat = 5; b_lat = 2;
        issue_wr(39'h3000, 1, 128'hA0);
        pulse();
        chk("t3_awvalid_busy", {m_axi_awvalid, dram_write_busy}, 2'b11);
        repeat (3) tick();
        chk("t3_w_before_aw", {m_axi_awvalid, (wsrc_q.size() == 0)}, 2'b11);
        wait_idle("t3_idle", 100);
        tick();
        chk("t3_drained", exp_w_q.size() + exp_aw_q.size(), 0);

        // concurrent read len=15 and write len=15
        aw_lat = 0; b_lat = 0;
        issue_rd(39'h4000, 15);
        issue_wr(39'h5000, 15, 128'hB00);
        pulse();
        chk("t4_both_busy", {dram_read_busy, dram_write_busy}, 2'b11);
        wait_idle("t4_idle", 300);
        tick();
        chk("t4_error", dram_error, 0);
        chk("t4_drained", exp_rd_q.size() + exp_w_q.size(), 0);

        // BRESP error is sticky until reset
        bresp_cfg = 2'b10;
        issue_wr(39'h6000, 0, 128'hC00);
        pulse();
        wait_idle("t5_wr_idle", 100);
        chk("t5_err_bresp", dram_error, 1);
        bresp_cfg = 2'b00;
        issue_rd(39'h6100, 1);
        pulse();
        wait_idle("t5_rd_idle", 100);
        tick();
        chk("t5_err_sticky", dram_error, 1);
        do_reset();
        chk("t5_err_cleared", dram_error, 0);

        // early RLAST on the second beat of a 4-beat read
        early_last = 1;
        issue_rd(39'h7000, 3);
        pulse();
        wait_idle("t5b_idle", 100);
        tick();
        early_last = -1;
        chk("t5b_err_rlast", dram_error, 1);
        chk("t5b_drained", exp_rd_q.size(), 0);
        do_reset();

        // reset in the middle of a read burst
        issue_rd(39'h8000, 15);
        pulse();
        repeat (6) tick();
        chk("t6_midburst_busy", dram_read_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        exp_rd_q.delete(); exp_ar_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        issue_rd(39'h9000, 2);
        pulse();
        wait_idle("t6_idle", 100);
        tick();
        chk("t6_error", dram_error, 0);

        chk("final_queues_empty", exp_rd_q.size() + exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "timeout");
    end

endmodule
